// File: rtl/gcd_arbiter_if.sv
// Requester-side bus of the GCD arbiter.
//   req     : per-requester request level
//   xi_bus  : packed x operands, requester i at [i*NBits +: NBits]
//   yi_bus  : packed y operands, same packing
//   done    : one-hot, one-cycle completion pulse
//   res     : result, valid while any done bit is high
//   err     : watchdog-abort flag, coincident with done
//   busy    : arbiter not idle
// slave modport = arbiter side, master modport = requester side.
interface gcd_arbiter_if #(
  parameter int NBits = 8,
  parameter int NReq  = 4
);
  logic [NReq-1:0]       req;
  logic [NReq*NBits-1:0] xi_bus;
  logic [NReq*NBits-1:0] yi_bus;
  logic [NReq-1:0]       done;
  logic [NBits-1:0]      res;
  logic                  err;
  logic                  busy;

  modport slave  (input  req, xi_bus, yi_bus, output done, res, err, busy);
  modport master (output req, xi_bus, yi_bus, input  done, res, err, busy);
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine between NReq requesters.
// Grants a pending request, loads its operands into the engine, runs the
// engine start/rdy handshake and returns the result with a one-cycle done
// pulse. A watchdog aborts (and resets) the engine after MaxCycles in RUN.
//   clk, rst      : clock, asynchronous active-low reset
//   bus           : requester interface (slave modport)
//   eng_xi/eng_yi : operands to engine
//   eng_start     : engine start (low = load, high = compute)
//   eng_rst       : engine reset, active-high
//   eng_xo/eng_rdy: engine result / result valid
module gcd_arbiter #(
  parameter int NBits     = 8,
  parameter int NReq      = 4,
  parameter int MaxCycles = 1024
) (
  input  logic             clk,
  input  logic             rst,
  gcd_arbiter_if.slave     bus,
  output logic [NBits-1:0] eng_xi,
  output logic [NBits-1:0] eng_yi,
  output logic             eng_start,
  output logic             eng_rst,
  input  logic [NBits-1:0] eng_xo,
  input  logic             eng_rdy
);
  localparam int IdW = $clog2(NReq);
  localparam int WdW = $clog2(MaxCycles);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [IdW-1:0]   id, id_n, rr, rr_n;
  logic [WdW-1:0]   wd, wd_n;
  logic [NBits-1:0] xi_n, yi_n, res_q, res_n;
  logic [NReq-1:0]  done_q, done_n;
  logic             err_q, err_n, busy_q, busy_n, start_n, erst_n;

  logic             found;
  logic [IdW-1:0]   win;
  logic [NBits-1:0] xsel, ysel;

  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

  // First pending request searching upward from rr+1 with wrap-around,
  // plus the operand slices of the winner.
  always_comb begin : pick
    int unsigned    j;
    logic [IdW-1:0] c;
    found = 1'b0;
    win   = '0;
    j     = 0;
    c     = '0;
    xsel  = '0;
    ysel  = '0;
    for (int unsigned k = 1; k <= NReq; k++) begin
      j = (32'(rr) + k) % 32'(NReq);
      c = IdW'(j);
      if (!found && bus.req[c]) begin
        found = 1'b1;
        win   = c;
      end
    end
    for (int unsigned k = 0; k < NReq; k++) begin
      if (IdW'(k) == win) begin
        xsel = bus.xi_bus[k*NBits +: NBits];
        ysel = bus.yi_bus[k*NBits +: NBits];
      end
    end
  end

  // Every output is a register; next values are computed here.
  always_comb begin
    state_n = state;
    id_n    = id;
    rr_n    = rr;
    wd_n    = wd;
    xi_n    = eng_xi;
    yi_n    = eng_yi;
    res_n   = res_q;
    done_n  = '0;
    err_n   = 1'b0;
    start_n = 1'b0;
    erst_n  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          id_n    = win;
          xi_n    = xsel;
          yi_n    = ysel;
          state_n = LOAD;
        end
      end
      LOAD: begin
        start_n = 1'b1;
        wd_n    = '0;
        state_n = RUN;
      end
      RUN: begin
        start_n = 1'b1;
        wd_n    = wd + 1'b1;
        if (eng_rdy) begin
          res_n      = eng_xo;
          done_n[id] = 1'b1;
          start_n    = 1'b0;
          state_n    = DONE;
        end else if (wd == WdW'(MaxCycles - 1)) begin
          res_n      = '0;
          done_n[id] = 1'b1;
          err_n      = 1'b1;
          erst_n     = 1'b1;
          start_n    = 1'b0;
          state_n    = DONE;
        end
      end
      DONE: begin
        rr_n    = id;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      id        <= '0;
      rr        <= IdW'(NReq - 1);
      wd        <= '0;
      eng_xi    <= '0;
      eng_yi    <= '0;
      res_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      eng_start <= 1'b0;
      eng_rst   <= 1'b1;
    end else begin
      state     <= state_n;
      id        <= id_n;
      rr        <= rr_n;
      wd        <= wd_n;
      eng_xi    <= xi_n;
      eng_yi    <= yi_n;
      res_q     <= res_n;
      done_q    <= done_n;
      err_q     <= err_n;
      busy_q    <= busy_n;
      eng_start <= start_n;
      eng_rst   <= erst_n;
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural subtractive GCD engine, scoreboard of
// expected {done, res, err} pushed when requests are raised and popped by a
// monitor on each done pulse.
module tb_gcd_arbiter;
  localparam int NB = 8;
  localparam int NR = 4;
  localparam int MC = 16;

  typedef struct packed {
    logic [NR-1:0] done;
    logic [NB-1:0] res;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] eng_xi, eng_yi, eng_xo, ex, ey;
  logic          eng_start, eng_rst, eng_rdy, m_rdy;
  logic          stall = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_done_cyc = -1000;
  int   reassert_budget = 0;
  int   pending [NR];
  int   ox [NR];
  int   oy [NR];
  exp_t sb [$];

  gcd_arbiter_if #(.NBits(NB), .NReq(NR)) bus ();

  gcd_arbiter #(.NBits(NB), .NReq(NR), .MaxCycles(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .eng_xi   (eng_xi),
    .eng_yi   (eng_yi),
    .eng_start(eng_start),
    .eng_rst  (eng_rst),
    .eng_xo   (eng_xo),
    .eng_rdy  (eng_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: load while start low, one subtraction step per cycle while high.
  assign eng_rdy = m_rdy & ~stall;
  always @(posedge clk) begin
    if (eng_rst) begin
      ex <= '0; ey <= '0; m_rdy <= 1'b0; eng_xo <= '0;
    end else if (!eng_start) begin
      ex <= eng_xi; ey <= eng_yi; m_rdy <= 1'b0;
    end else if (!m_rdy) begin
      if (ex == 0 || ey == 0) begin eng_xo <= '0; m_rdy <= 1'b1; end
      else if (ex == ey)      begin eng_xo <= ex; m_rdy <= 1'b1; end
      else if (ex > ey)       ex <= ex - ey;
      else                    ey <= ey - ex;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    if (a == 0 || b == 0) return 0;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  task automatic set_ops(input int i, input int x, input int y);
    ox[i] = x;
    oy[i] = y;
    bus.xi_bus[i*NB +: NB] = NB'(x);
    bus.yi_bus[i*NB +: NB] = NB'(y);
  endtask

  task automatic push_exp(input int i, input bit e);
    exp_t s;
    s.done = NR'(1) << i;
    s.res  = e ? '0 : NB'(gcd_ref(ox[i], oy[i]));
    s.err  = e;
    sb.push_back(s);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && bus.req == '0) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Monitor: compare each done pulse against the scoreboard and play the
  // requester role (drop req after done, optionally reassert 2 cycles later).
  initial begin
    exp_t s;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (pending[i] > 0) begin
          pending[i]--;
          if (pending[i] == 0) begin
            push_exp(i, 1'b0);
            bus.req[i] = 1'b1;
          end
        end
      end
      if (bus.done != '0) begin
        chk("done_gap_ge4", 32'(cyc - last_done_cyc >= 4), 1);
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          chk("extra_done", 32'(bus.done), 0);
        end else begin
          s = sb.pop_front();
          chk("done_id", 32'(bus.done), 32'(s.done));
          chk("res", 32'(bus.res), 32'(s.res));
          chk("err", 32'(bus.err), 32'(s.err));
          chk("eng_rst_at_done", 32'(eng_rst), 32'(s.err));
          chk("eng_start_at_done", 32'(eng_start), 0);
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.done[i]) begin
            bus.req[i] = 1'b0;
            if (reassert_budget > 0) begin
              reassert_budget--;
              pending[i] = 2;
            end
          end
        end
      end
    end
  end

  initial begin
    int g;
    bit seen;
    bus.req    = '0;
    bus.xi_bus = '0;
    bus.yi_bus = '0;
    for (int i = 0; i < NR; i++) begin ox[i] = 0; oy[i] = 0; end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_res", 32'(bus.res), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_rst", 32'(eng_rst), 1);
    chk("rst_eng_xi", 32'(eng_xi), 0);
    chk("rst_eng_yi", 32'(eng_yi), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("eng_rst_release", 32'(eng_rst), 0);

    // 1: single request
    @(negedge clk);
    set_ops(0, 12, 8);
    push_exp(0, 1'b0);
    bus.req[0] = 1'b1;
    @(posedge clk); #1;
    chk("t1_busy_after_grant", 32'(bus.busy), 1);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    chk("t1_done_seen", 32'(seen), 1);
    @(negedge clk);
    chk("t1_busy_low_after_done", 32'(bus.busy), 0);
    drain("t1");

    // 2: two simultaneous requests
    set_ops(1, 21, 14);
    set_ops(3, 9, 6);
    push_exp(1, 1'b0);
    push_exp(3, 1'b0);
    bus.req = bus.req | 4'b1010;
    drain("t2");

    // 3: all requesting, two of them reassert
    set_ops(0, 15, 10);
    set_ops(1, 8, 12);
    set_ops(2, 49, 14);
    set_ops(3, 7, 3);
    for (int i = 0; i < NR; i++) push_exp(i, 1'b0);
    reassert_budget = 2;
    bus.req = '1;
    drain("t3");

    // 4: zero operand
    set_ops(2, 0, 35);
    push_exp(2, 1'b0);
    bus.req[2] = 1'b1;
    drain("t4");

    // 5: engine never ready -> watchdog abort, then a normal service
    stall = 1'b1;
    set_ops(1, 30, 12);
    push_exp(1, 1'b1);
    bus.req[1] = 1'b1;
    @(posedge clk); #1;
    g = cyc;
    drain("t5_abort");
    chk("t5_abort_latency", 32'(last_done_cyc - g), 32'(1 + MC));
    stall = 1'b0;
    @(negedge clk);
    push_exp(1, 1'b0);
    bus.req[1] = 1'b1;
    drain("t5_recover");

    // 6: reset during RUN
    set_ops(0, 12, 8);
    bus.req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    chk("t6_run_reached", 32'(seen), 1);
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_done", 32'(bus.done), 0);
    chk("t6_eng_rst", 32'(eng_rst), 1);
    chk("t6_eng_start", 32'(eng_start), 0);
    chk("t6_eng_xi", 32'(eng_xi), 0);
    chk("t6_res", 32'(bus.res), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_done_in_reset", 32'(bus.done), 0);
    push_exp(0, 1'b0);
    rst = 1'b1;
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
